// File: rtl/loop_index_gen_if.sv
// Handshake and bound signals between the loop index generator
// and its controller / index consumer.
interface loop_index_gen_if #(
  parameter int SIZE_ADDR = 8
);
  logic [SIZE_ADDR-1:0]   i_num_rows;
  logic [SIZE_ADDR-1:0]   i_num_cols;
  logic                   i_mode;
  logic                   i_start;
  logic                   i_abort;
  logic                   i_ready;
  logic                   o_valid;
  logic [SIZE_ADDR-1:0]   o_idx_i;
  logic [SIZE_ADDR-1:0]   o_idx_j;
  logic                   o_last_j;
  logic                   o_last;
  logic                   o_busy;
  logic [2*SIZE_ADDR-1:0] o_count;
  logic                   o_done;

  modport master (
    input  i_num_rows,
    input  i_num_cols,
    input  i_mode,
    input  i_start,
    input  i_abort,
    input  i_ready,
    output o_valid,
    output o_idx_i,
    output o_idx_j,
    output o_last_j,
    output o_last,
    output o_busy,
    output o_count,
    output o_done
  );

  modport slave (
    output i_num_rows,
    output i_num_cols,
    output i_mode,
    output i_start,
    output i_abort,
    output i_ready,
    input  o_valid,
    input  o_idx_i,
    input  o_idx_j,
    input  o_last_j,
    input  o_last,
    input  o_busy,
    input  o_count,
    input  o_done
  );
endinterface

// File: rtl/loop_index_gen.sv
// Two-level (i, j) loop index generator, rectangular or
// upper-triangular, with valid/ready backpressure and abort.
module loop_index_gen #(
  parameter int SIZE_ADDR = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  loop_index_gen_if.master bus
);
  localparam int CW = 2 * SIZE_ADDR;
  localparam logic [SIZE_ADDR-1:0] ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [SIZE_ADDR-1:0] i_q, i_d;
  logic [SIZE_ADDR-1:0] j_q, j_d;
  logic [SIZE_ADDR-1:0] cols_q, cols_d;
  logic [SIZE_ADDR-1:0] reff_q, reff_d;
  logic mode_q, mode_d;
  logic [CW-1:0] count_q, count_d;

  logic run;
  logic last_j;
  logic last;
  logic fire;
  logic zero_bnd;
  logic [SIZE_ADDR-1:0] reff_new;
  logic [SIZE_ADDR-1:0] i_nxt;

  // Row-end / sweep-end flags and the effective row count at start.
  always_comb begin
    run      = (state_q == S_RUN);
    last_j   = run && (j_q == cols_q - ONE);
    last     = last_j && (i_q == reff_q - ONE);
    fire     = run && bus.i_ready;
    i_nxt    = i_q + ONE;
    zero_bnd = (bus.i_num_rows == '0) ||
               (bus.i_num_cols == '0);
    reff_new = bus.i_num_rows;
    if (bus.i_mode &&
        (bus.i_num_cols < bus.i_num_rows))
      reff_new = bus.i_num_cols;
  end

  // Next-state and index stepping; abort outranks everything.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    cols_d  = cols_q;
    reff_d  = reff_q;
    mode_d  = mode_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.i_abort && bus.i_start) begin
          cols_d  = bus.i_num_cols;
          reff_d  = reff_new;
          mode_d  = bus.i_mode;
          count_d = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = zero_bnd ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.i_abort) begin
          state_d = S_IDLE;
        end else if (fire) begin
          count_d = count_q + CNT_ONE;
          if (last) begin
            state_d = S_DONE;
          end else if (last_j) begin
            i_d = i_nxt;
            j_d = mode_q ? i_nxt : '0;
          end else begin
            j_d = j_q + ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      cols_q  <= '0;
      reff_q  <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cols_q  <= cols_d;
      reff_q  <= reff_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.o_valid  = run;
    bus.o_idx_i  = i_q;
    bus.o_idx_j  = j_q;
    bus.o_last_j = last_j;
    bus.o_last   = last;
    bus.o_busy   = run || (state_q == S_DONE);
    bus.o_count  = count_q;
    bus.o_done   = (state_q == S_DONE);
  end
endmodule
